// File: rtl/lupa_sensor_emu.sv
// -----------------------------------------------------------------------------
// lupa_sensor_emu
//   Transmit-side model of the LUPA300 parallel pixel port. Produces
//   oDATA_IMAGE / oLINE_VALID / oFRAME_VALID with programmable geometry and
//   blanking and one of four test patterns. It stands in for a real sensor
//   when exercising the capture path and the SDRAM/HDMI chain.
//
//   Ports
//     iCLOCK_80     in   pixel clock, all logic on the rising edge
//     RST_N         in   asynchronous active-low reset
//     iENABLE       in   1 = generate frames (sampled in IDLE / at VBLANK end)
//     iMODE[1:0]    in   0 H-ramp, 1 V-ramp, 2 checkerboard, 3 moving ramp
//     iINT_TIME     in   (LUPA_EMU_SLAVE_EN only) async frame trigger
//     oDATA_IMAGE   out  pixel value, 0 whenever oLINE_VALID = 0
//     oLINE_VALID   out  line valid
//     oFRAME_VALID  out  frame valid
//     oFRAME_CNT    out  completed frames, 8-bit wrapping
//     oBUSY         out  1 while the sequencer is not IDLE
//
//   Build option
//     LUPA_EMU_SLAVE_EN : when defined, a frame may only start after a
//     synchronised rising edge of iINT_TIME seen while FRAME_VALID is low.
//     When undefined the generator free-runs and iINT_TIME does not exist.
//
//   All outputs are registered. The output flops are loaded from the
//   next-state values so that they line up exactly with the state register.
// -----------------------------------------------------------------------------
module lupa_sensor_emu #(
   parameter int DATA_W   = 10,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 40,
   parameter int FV_SETUP = 8,
   parameter int FV_HOLD  = 8,
   parameter int V_BLANK  = 400,
   parameter int CHK_LOG2 = 3
) (
   input  logic              iCLOCK_80,
   input  logic              RST_N,
   input  logic              iENABLE,
   input  logic [1:0]        iMODE,
`ifdef LUPA_EMU_SLAVE_EN
   input  logic              iINT_TIME,
`endif
   output logic [DATA_W-1:0] oDATA_IMAGE,
   output logic              oLINE_VALID,
   output logic              oFRAME_VALID,
   output logic [7:0]        oFRAME_CNT,
   output logic              oBUSY
);

   // One phase counter serves every timed state, so it is sized for the longest phase.
   localparam int MAX_A   = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
   localparam int MAX_B   = (FV_SETUP > FV_HOLD) ? FV_SETUP : FV_HOLD;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_MAX = (MAX_C > V_BLANK) ? MAX_C : V_BLANK;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int ROW_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   // Terminal counts; a zero-length phase never uses its value.
   localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(FV_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(FV_HOLD - 1);
   localparam logic [CNT_W-1:0] VB_LAST    = CNT_W'(V_BLANK - 1);
   localparam logic [ROW_W-1:0] V_LAST     = ROW_W'(V_ACTIVE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FV_LEAD, S_LINE, S_HBLANK, S_FV_TRAIL, S_VBLANK
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [1:0]          mode_q, mode_d;
   logic [7:0]          fcnt_q, fcnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                lv_q, lv_d;
   logic                fv_q, fv_d;
   logic                busy_q, busy_d;
   logic                start_ok;
   logic                go_trail, go_fall, go_vend, go_start;

   // Pattern generator; arithmetic is done at 32 bits and truncated to DATA_W.
   function automatic logic [DATA_W-1:0] pix_value(input logic [1:0]       mode,
                                                   input logic [CNT_W-1:0] col,
                                                   input logic [ROW_W-1:0] row,
                                                   input logic [7:0]       fcnt);
      logic chk;
      chk = (((32'(col) >> CHK_LOG2) & 32'd1) != ((32'(row) >> CHK_LOG2) & 32'd1));
      case (mode)
         2'd0:    pix_value = DATA_W'(col);
         2'd1:    pix_value = DATA_W'(row);
         2'd2:    pix_value = {DATA_W{chk}};
         2'd3:    pix_value = DATA_W'(32'(col) + 32'(row) + 32'(fcnt));
         default: pix_value = '0;
      endcase
   endfunction

`ifdef LUPA_EMU_SLAVE_EN
   logic [2:0] int_sync_q, int_sync_d;
   logic       armed_q, armed_d;
   logic       int_rise;

   // Two synchroniser stages plus one history stage for edge detection.
   assign int_sync_d = {int_sync_q[1:0], iINT_TIME};
   assign int_rise   = int_sync_q[1] & ~int_sync_q[2];
   // A pending trigger also counts when it lands on the very cycle the frame may start.
   assign start_ok   = iENABLE & (armed_q | int_rise);

   // Trigger synchroniser and the armed flag that remembers an edge seen while FV is low.
   always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
      if (!RST_N) begin
         int_sync_q <= 3'b000;
         armed_q    <= 1'b0;
      end else begin
         int_sync_q <= int_sync_d;
         armed_q    <= armed_d;
      end
   end
`else
   assign start_ok = iENABLE;
`endif

   // State register, counters, mode latch and registered outputs.
   always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         mode_q  <= 2'd0;
         fcnt_q  <= 8'd0;
         data_q  <= '0;
         lv_q    <= 1'b0;
         fv_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         mode_q  <= mode_d;
         fcnt_q  <= fcnt_d;
         data_q  <= data_d;
         lv_q    <= lv_d;
         fv_q    <= fv_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic. Phase ends raise go_* flags which are then resolved in
   // order, so that any zero-length phase is skipped in the same cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      row_d    = row_q;
      mode_d   = mode_q;
      fcnt_d   = fcnt_q;
      go_trail = 1'b0;
      go_fall  = 1'b0;
      go_vend  = 1'b0;
      go_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_ok) go_start = 1'b1;
            else          state_d  = S_IDLE;
         end
         S_FV_LEAD: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_LINE;
               cnt_d   = '0;
            end else begin
               state_d = S_FV_LEAD;
            end
         end
         S_LINE: begin
            if (cnt_q == H_ACT_LAST) begin
               if (row_q == V_LAST) begin
                  go_trail = 1'b1;
               end else begin
                  row_d   = row_q + 1'b1;
                  cnt_d   = '0;
                  state_d = (H_BLANK != 0) ? S_HBLANK : S_LINE;
               end
            end else begin
               state_d = S_LINE;
            end
         end
         S_HBLANK: begin
            if (cnt_q == HB_LAST) begin
               state_d = S_LINE;
               cnt_d   = '0;
            end else begin
               state_d = S_HBLANK;
            end
         end
         S_FV_TRAIL: begin
            if (cnt_q == HOLD_LAST) go_fall = 1'b1;
            else                    state_d = S_FV_TRAIL;
         end
         S_VBLANK: begin
            if (cnt_q == VB_LAST) go_vend = 1'b1;
            else                  state_d = S_VBLANK;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (go_trail) begin
         if (FV_HOLD != 0) begin
            state_d = S_FV_TRAIL;
            cnt_d   = '0;
         end else begin
            go_fall = 1'b1;
         end
      end else begin
         go_fall = go_fall;
      end

      // FRAME_VALID falls here, so the frame counter steps with it.
      if (go_fall) begin
         fcnt_d = fcnt_q + 8'd1;
         if (V_BLANK != 0) begin
            state_d = S_VBLANK;
            cnt_d   = '0;
         end else begin
            go_vend = 1'b1;
         end
      end else begin
         fcnt_d = fcnt_d;
      end

      if (go_vend) begin
         if (start_ok) begin
            go_start = 1'b1;
         end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      end else begin
         go_start = go_start;
      end

      // Frame start: the pattern mode is frozen for the whole frame.
      if (go_start) begin
         mode_d  = iMODE;
         row_d   = '0;
         cnt_d   = '0;
         state_d = (FV_SETUP != 0) ? S_FV_LEAD : S_LINE;
      end else begin
         mode_d = mode_d;
      end

`ifdef LUPA_EMU_SLAVE_EN
      if (go_start)
         armed_d = 1'b0;
      else if (int_rise && (state_q == S_IDLE || state_q == S_VBLANK))
         armed_d = 1'b1;
      else
         armed_d = armed_q;
`endif
   end

   // Output decode from the next state, loaded into the output flops.
   always_comb begin
      fv_d   = 1'b0;
      lv_d   = 1'b0;
      data_d = '0;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_FV_LEAD, S_HBLANK, S_FV_TRAIL: fv_d = 1'b1;
         S_LINE: begin
            fv_d   = 1'b1;
            lv_d   = 1'b1;
            data_d = pix_value(mode_d, cnt_d, row_d, fcnt_d);
         end
         default: fv_d = 1'b0;
      endcase
   end

   assign oDATA_IMAGE  = data_q;
   assign oLINE_VALID  = lv_q;
   assign oFRAME_VALID = fv_q;
   assign oFRAME_CNT   = fcnt_q;
   assign oBUSY        = busy_q;

endmodule

// File: tb/tb_lupa_sensor_emu.sv
// Directed bench for lupa_sensor_emu with a pixel scoreboard: expected pixels
// are queued when a run is started and popped as oLINE_VALID pixels appear.
// Timing of FV/LV phases is measured on the falling clock edge.
module tb_lupa_sensor_emu;
   localparam int DATA_W   = 10;
   localparam int H_ACTIVE = 8;
   localparam int V_ACTIVE = 4;
   localparam int H_BLANK  = 3;
   localparam int FV_SETUP = 2;
   localparam int FV_HOLD  = 2;
   localparam int V_BLANK  = 5;
   localparam int CHK_LOG2 = 1;
   localparam int FV_TOTAL = FV_SETUP + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + FV_HOLD;
   localparam int SEL_FV = 0, SEL_LV = 1;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b1;
   logic              enable = 1'b0;
   logic [1:0]        mode   = 2'd0;
   logic [DATA_W-1:0] data;
   logic              lv, fv, busy;
   logic [7:0]        fcnt;
`ifdef LUPA_EMU_SLAVE_EN
   logic              int_time = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int exp_fcnt = 0;

   // monitor state
   bit mon_en = 1'b0;
   bit fv_p = 1'b0, lv_p = 1'b0, per_valid = 1'b0, gap_seen = 1'b0;
   int per_cnt = 0, fv_len = 0, lv_len = 0, low_cnt = 0, lines = 0;

   lupa_sensor_emu #(
      .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .FV_SETUP(FV_SETUP), .FV_HOLD(FV_HOLD), .V_BLANK(V_BLANK), .CHK_LOG2(CHK_LOG2)
   ) dut (
      .iCLOCK_80   (clk),
      .RST_N       (rst_n),
      .iENABLE     (enable),
      .iMODE       (mode),
`ifdef LUPA_EMU_SLAVE_EN
      .iINT_TIME   (int_time),
`endif
      .oDATA_IMAGE (data),
      .oLINE_VALID (lv),
      .oFRAME_VALID(fv),
      .oFRAME_CNT  (fcnt),
      .oBUSY       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int exp_pix(input int m, input int col, input int row, input int fc);
      case (m)
         0:       return col % (1 << DATA_W);
         1:       return row % (1 << DATA_W);
         2:       return ((((col >> CHK_LOG2) ^ (row >> CHK_LOG2)) & 1) != 0) ? (1 << DATA_W) - 1 : 0;
         default: return (col + row + fc) % (1 << DATA_W);
      endcase
   endfunction

   // One falling-edge sample: scoreboard pixels and measure FV/LV phase lengths.
   task automatic tick();
      @(negedge clk);
      if (mon_en) begin
         if (fv && !fv_p) begin
            if (per_valid && !gap_seen) check("fv_period", per_cnt, FV_TOTAL + V_BLANK);
            per_cnt = 0; per_valid = 1'b1; gap_seen = 1'b0;
            fv_len = 0; lines = 0; low_cnt = 0;
         end
         if (!fv && fv_p) begin
            check("fv_high", fv_len, FV_TOTAL);
            check("lines_per_frame", lines, V_ACTIVE);
            check("fv_hold", low_cnt, FV_HOLD);
         end
         if (lv && !lv_p) begin
            if (lines == 0) check("fv_setup", low_cnt, FV_SETUP);
            else            check("h_blank", low_cnt, H_BLANK);
         end
         if (!lv && lv_p) begin
            check("lv_len", lv_len, H_ACTIVE);
            lines++;
            low_cnt = 0;
         end
         if (lv) begin
            check("lv_inside_fv", fv, 1);
            check("pix_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("pix", data, exp_q.pop_front());
            lv_len++;
         end else begin
            check("data_blank", data, 0);
            lv_len = 0;
         end
         if (fv && !lv) low_cnt++;
         if (fv) fv_len++;
         per_cnt++;
         if (!busy) gap_seen = 1'b1;
      end else begin
         per_valid = 1'b0; gap_seen = 1'b0;
         per_cnt = 0; fv_len = 0; lv_len = 0; low_cnt = 0; lines = 0;
      end
      fv_p = fv;
      lv_p = lv;
   endtask

   task automatic wait_sig(input int which, input logic level, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         tick();
         if (((which == SEL_FV) ? fv : lv) === level) hit = 1'b1;
      end
      check({tag, "_reached"}, hit, 1);
   endtask

   // Runs n frames of pattern m; enable is dropped during the last frame,
   // either at its FV rise or at row 1 col 4.
   task automatic run_frames(input int m, input int n, input bit drop_mid, input int mode_after);
      bit saw_fv;
      for (int k = 0; k < n; k++)
         for (int r = 0; r < V_ACTIVE; r++)
            for (int c = 0; c < H_ACTIVE; c++)
               exp_q.push_back(exp_pix(m, c, r, (exp_fcnt + k) % 256));
      mode   = 2'(m);
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
         wait_sig(SEL_FV, 1'b1, "fv_rise");
         if (k == n - 1) begin
            mode = 2'(mode_after);
            if (drop_mid) begin
               wait_sig(SEL_LV, 1'b1, "row0_start");
               wait_sig(SEL_LV, 1'b0, "row0_end");
               wait_sig(SEL_LV, 1'b1, "row1_start");
               repeat (4) tick();
            end
            enable = 1'b0;
         end
         wait_sig(SEL_FV, 1'b0, "fv_fall");
         exp_fcnt = (exp_fcnt + 1) % 256;
         check("frame_cnt", fcnt, exp_fcnt);
      end
      check("busy_vblank_first", busy, 1);
      repeat (4) tick();
      check("busy_vblank_last", busy, 1);
      tick();
      check("busy_idle", busy, 0);
      saw_fv = 1'b0;
      repeat (20) begin
         tick();
         if (fv) saw_fv = 1'b1;
      end
      check("no_restart", saw_fv, 0);
      check("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      // reset state
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check("rst_data", data, 0);
      check("rst_lv", lv, 0);
      check("rst_fv", fv, 0);
      check("rst_fcnt", fcnt, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle_no_enable", busy, 0);
      mon_en = 1'b1;

      // moving ramp over three frames, first pixel = frame count
      run_frames(3, 3, 1'b0, 3);
      // horizontal ramp, two back-to-back frames, enable dropped at row 1 col 4
      run_frames(0, 2, 1'b1, 0);
      // checkerboard; mode change during the frame must be ignored
      run_frames(2, 1, 1'b0, 1);
      // vertical ramp
      run_frames(1, 1, 1'b0, 1);

      // reset in the middle of a line
      mon_en = 1'b0;
      mode   = 2'd0;
      enable = 1'b1;
      wait_sig(SEL_FV, 1'b1, "abort_fv_rise");
      wait_sig(SEL_LV, 1'b1, "abort_lv_rise");
      repeat (3) tick();
      check("pre_abort_lv", lv, 1);
      #2 rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("abort_lv", lv, 0);
      check("abort_fv", fv, 0);
      check("abort_data", data, 0);
      check("abort_busy", busy, 0);
      check("abort_fcnt", fcnt, 0);
      exp_q.delete();
      exp_fcnt = 0;
      tick();
      rst_n = 1'b1;
      tick();
      mon_en = 1'b1;
      run_frames(0, 1, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
